// File: rtl/rv_pkg.sv
// Shared register-file types: architectural widths and the writeback payload
// carried through the accelerator result FIFO.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO of writeback entries. The head is read
// combinationally so the arbiter can write it to the register file in the pop cycle.
module sync_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  wb_entry_t                push_data_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard locally so a stray request can never corrupt the occupancy count.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges core writebacks with buffered accelerator results onto the single register-file
// write port, tracks pending accelerator destinations, and requests core bubbles on starvation.
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_wb_en,
    input  logic [REG_AW-1:0] core_wb_rd,
    input  logic [XLEN-1:0]   core_wb_data,
    input  logic              acc_issue,
    input  logic [REG_AW-1:0] acc_issue_rd,
    input  logic              acc_resp_valid,
    output logic              acc_resp_ready,
    input  logic [REG_AW-1:0] acc_resp_rd,
    input  logic [XLEN-1:0]   acc_resp_data,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rd_busy,
    output logic              stall_req,
    output logic              write_reg,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   data_in
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    wb_entry_t          head;
    wb_entry_t          push_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      count_d;
    logic               core_sel;
    logic               push;
    logic               pop;
    logic               head_clr;
    logic               starve;
    logic [WW-1:0]      wait_q, wait_d;
    logic               stall_q, stall_d;
    logic [NREGS-1:0]   busy_q, busy_d;

    assign push_entry = '{rd: acc_resp_rd, data: acc_resp_data};

    sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Core owns the port unless a stall is in force; any unused slot drains the FIFO head.
    always_comb begin
        core_sel       = !stall_q && core_wb_en && (core_wb_rd != '0);
        pop            = !core_sel && !fifo_empty;
        head_clr       = pop && (head.rd != '0);
        acc_resp_ready = !fifo_full && !reset;
        push           = acc_resp_valid && acc_resp_ready;

        write_reg = 1'b0;
        rd        = head.rd;
        data_in   = head.data;
        if (core_sel) begin
            write_reg = 1'b1;
            rd        = core_wb_rd;
            data_in   = core_wb_data;
        end else if (head_clr) begin
            write_reg = 1'b1;
        end
    end

    // A new issue to a register outranks the retirement of an older result to it.
    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_busy
            assign busy_d[gi] = (acc_issue && (acc_issue_rd == REG_AW'(gi)))
                              || (busy_q[gi] && !(head_clr && (head.rd == REG_AW'(gi))));
        end
    endgenerate
    assign busy_d[0] = 1'b0;

    assign rs1_busy = busy_q[dec_rs1];
    assign rs2_busy = busy_q[dec_rs2];
    assign rd_busy  = busy_q[dec_rd];

    always_comb begin
        count_d = fifo_count + CW'(push) - CW'(pop);
        starve  = !fifo_empty && !pop && (wait_q == WW'(MAX_WAIT - 1));
        wait_d  = wait_q;
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (wait_q != WW'(MAX_WAIT - 1)) begin
            wait_d = wait_q + 1'b1;
        end
        stall_d = starve || (count_d == CW'(DEPTH));
    end

    assign stall_req = stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a queue-based reference
// model of the writeback port, busy table and starvation stall.
module tb_wb_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_wb_en;
    logic [4:0]  core_wb_rd;
    logic [31:0] core_wb_data;
    logic        acc_issue;
    logic [4:0]  acc_issue_rd;
    logic        acc_resp_valid;
    logic        acc_resp_ready;
    logic [4:0]  acc_resp_rd;
    logic [31:0] acc_resp_data;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        stall_req;
    logic        write_reg;
    logic [4:0]  rd;
    logic [31:0] data_in;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending results in arrival order, pending-destination flags,
    // how long the current head has waited, and whether a bubble is being demanded.
    int          q_rd[$];
    logic [31:0] q_data[$];
    bit          m_busy[32];
    int          m_age;
    bit          m_stall;

    wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .core_wb_en     (core_wb_en),
        .core_wb_rd     (core_wb_rd),
        .core_wb_data   (core_wb_data),
        .acc_issue      (acc_issue),
        .acc_issue_rd   (acc_issue_rd),
        .acc_resp_valid (acc_resp_valid),
        .acc_resp_ready (acc_resp_ready),
        .acc_resp_rd    (acc_resp_rd),
        .acc_resp_data  (acc_resp_data),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rd         (dec_rd),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .rd_busy        (rd_busy),
        .stall_req      (stall_req),
        .write_reg      (write_reg),
        .rd             (rd),
        .data_in        (data_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_rd.delete();
        q_data.delete();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_age   = 0;
        m_stall = 1'b0;
    endtask

    task automatic idle_inputs();
        core_wb_en     = 1'b0;
        core_wb_rd     = '0;
        core_wb_data   = '0;
        acc_issue      = 1'b0;
        acc_issue_rd   = '0;
        acc_resp_valid = 1'b0;
        acc_resp_rd    = '0;
        acc_resp_data  = '0;
    endtask

    // One clock: compare the DUT against the model mid-cycle, then advance the model.
    task automatic step();
        bit core_sel;
        bit pop;
        int sz;
        @(negedge clk);
        sz       = q_rd.size();
        core_sel = !m_stall && core_wb_en && (core_wb_rd != 0);
        pop      = !core_sel && (sz > 0);
        check("ready", 32'(acc_resp_ready), 32'(sz < DEPTH));
        check("stall", 32'(stall_req), 32'(m_stall));
        check("rs1_busy", 32'(rs1_busy), 32'(m_busy[dec_rs1]));
        check("rs2_busy", 32'(rs2_busy), 32'(m_busy[dec_rs2]));
        check("rd_busy", 32'(rd_busy), 32'(m_busy[dec_rd]));
        if (core_sel) begin
            check("wr_en", 32'(write_reg), 32'd1);
            check("wr_rd", 32'(rd), 32'(core_wb_rd));
            check("wr_data", data_in, core_wb_data);
        end else if (pop && q_rd[0] != 0) begin
            check("wr_en", 32'(write_reg), 32'd1);
            check("wr_rd", 32'(rd), 32'(q_rd[0]));
            check("wr_data", data_in, q_data[0]);
        end else begin
            check("wr_en", 32'(write_reg), 32'd0);
        end
        if (pop) begin
            if (q_rd[0] != 0) m_busy[q_rd[0]] = 1'b0;
            void'(q_rd.pop_front());
            void'(q_data.pop_front());
        end
        if (acc_issue && acc_issue_rd != 0) m_busy[acc_issue_rd] = 1'b1;
        if (acc_resp_valid && sz < DEPTH) begin
            q_rd.push_back(int'(acc_resp_rd));
            q_data.push_back(acc_resp_data);
        end
        m_stall = (q_rd.size() == DEPTH) || (sz > 0 && !pop && m_age >= MAX_WAIT - 1);
        m_age   = (sz == 0 || pop) ? 0 : m_age + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            step();
        end
    endtask

    initial begin
        idle_inputs();
        dec_rs1 = 5'd0;
        dec_rs2 = 5'd0;
        dec_rd  = 5'd0;
        reset   = 1'b1;
        #2;
        check("rst_ready", 32'(acc_resp_ready), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_wr_en", 32'(write_reg), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Core write passes straight through in the same cycle.
        core_wb_en = 1'b1; core_wb_rd = 5'd5; core_wb_data = 32'hDEADBEEF;
        #1;
        check("t1_wr_en", 32'(write_reg), 32'd1);
        check("t1_wr_rd", 32'(rd), 32'd5);
        check("t1_wr_data", data_in, 32'hDEADBEEF);
        step();

        // Issue to r7, result three cycles later, busy until the FIFO writes it.
        idle_inputs();
        dec_rd = 5'd7;
        acc_issue = 1'b1; acc_issue_rd = 5'd7;
        step();
        drain(3);
        acc_resp_valid = 1'b1; acc_resp_rd = 5'd7; acc_resp_data = 32'h12;
        step();
        drain(1);
        check("t2_busy_clr", 32'(rd_busy), 32'd0);

        // Continuous core traffic starves one entry until a bubble is demanded.
        idle_inputs();
        core_wb_en = 1'b1; core_wb_rd = 5'd1; core_wb_data = 32'h1;
        acc_resp_valid = 1'b1; acc_resp_rd = 5'd11; acc_resp_data = 32'h33;
        step();
        acc_resp_valid = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            core_wb_rd = 5'd2; core_wb_data = 32'(i);
            step();
        end
        check("t3_stall_set", 32'(stall_req), 32'd1);
        drain(1);
        check("t3_stall_clr", 32'(stall_req), 32'd0);

        // Fill the FIFO under core traffic, then drain it in order.
        for (int i = 0; i < DEPTH; i++) begin
            core_wb_en = 1'b1; core_wb_rd = 5'd3; core_wb_data = 32'hC0 + 32'(i);
            acc_resp_valid = 1'b1; acc_resp_rd = 5'(12 + i); acc_resp_data = 32'hA0 + 32'(i);
            step();
        end
        check("t4_ready_full", 32'(acc_resp_ready), 32'd0);
        check("t4_stall_full", 32'(stall_req), 32'd1);
        drain(DEPTH + 1);

        // A fresh issue to r9 in the cycle its older result retires keeps r9 busy.
        idle_inputs();
        acc_issue = 1'b1; acc_issue_rd = 5'd9;
        step();
        idle_inputs();
        acc_resp_valid = 1'b1; acc_resp_rd = 5'd9; acc_resp_data = 32'h99;
        step();
        idle_inputs();
        acc_issue = 1'b1; acc_issue_rd = 5'd9;
        step();
        idle_inputs();
        dec_rd = 5'd9;
        #1;
        check("t5_busy_kept", 32'(rd_busy), 32'd1);
        acc_resp_valid = 1'b1; acc_resp_rd = 5'd0; acc_resp_data = 32'h55;
        step();
        drain(2);

        // Reset with entries pending and busy bits set clears everything at once.
        dec_rs1 = 5'd3; dec_rs2 = 5'd4; dec_rd = 5'd5;
        for (int i = 0; i < 3; i++) begin
            core_wb_en = 1'b1; core_wb_rd = 5'd1; core_wb_data = 32'h7;
            acc_issue = 1'b1; acc_issue_rd = 5'(3 + i);
            acc_resp_valid = 1'b1; acc_resp_rd = 5'(3 + i); acc_resp_data = 32'hB0 + 32'(i);
            step();
        end
        idle_inputs();
        #1;
        check("t6_busy_pre", 32'(rd_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_ready", 32'(acc_resp_ready), 32'd0);
        check("t6_stall", 32'(stall_req), 32'd0);
        check("t6_rs1_busy", 32'(rs1_busy), 32'd0);
        check("t6_rs2_busy", 32'(rs2_busy), 32'd0);
        check("t6_rd_busy", 32'(rd_busy), 32'd0);
        check("t6_wr_en", 32'(write_reg), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        drain(2);

        // Randomized traffic with heavy register overlap.
        for (int i = 0; i < 400; i++) begin
            core_wb_en     = ($urandom_range(0, 99) < 60);
            core_wb_rd     = 5'($urandom_range(0, 31));
            core_wb_data   = $urandom();
            acc_issue      = ($urandom_range(0, 99) < 40);
            acc_issue_rd   = 5'($urandom_range(0, 7));
            acc_resp_valid = ($urandom_range(0, 99) < 40);
            acc_resp_rd    = 5'($urandom_range(0, 7));
            acc_resp_data  = $urandom();
            dec_rs1        = 5'($urandom_range(0, 7));
            dec_rs2        = 5'($urandom_range(0, 7));
            dec_rd         = 5'($urandom_range(0, 7));
            step();
        end
        drain(DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
